// File: rtl/pkt_pkg.sv
// Shared packet-format definitions for the ingress and egress sides.
package pkt_pkg;

    // Words per memory block; a packet is L blocks long.
    localparam int BLOCK_WORDS = 8;

    // Header word 0 field positions.
    localparam int LEN_MSB     = 26;
    localparam int LEN_LSB     = 21;
    localparam int DMAC_HI_MSB = 15;
    localparam int DMAC_HI_LSB = 0;

    // Word indices inside the header.
    localparam int W_DMAC_LO = 1;
    localparam int W_TS      = 2;

    // Word counter width: up to 63 blocks * 8 words = 504 words.
    localparam int WCNT_W = 9;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_HDR  = 2'd1,
        E_BODY = 2'd2
    } egress_state_e;

    // A zero length field is malformed; such packets are taken as one block.
    function automatic logic [5:0] fix_len(input logic [5:0] len_blocks);
        return (len_blocks == 6'd0) ? 6'd1 : len_blocks;
    endfunction

endpackage

// File: rtl/egress_fifo.sv
// Synchronous show-ahead word FIFO. The head word is always visible on
// rdata_o while empty_o is low; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module egress_fifo #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/egress_port.sv
// Egress sink: delimits packets from the header length, measures
// ingress-to-egress latency, keeps statistics and buffers every accepted
// word for host readout.
//
// Handshakes: a word is transferred on packet_in whenever packet_in_en is
// high (there is no backpressure; a word that finds the FIFO full is dropped
// and counted). On the read side out_valid means out_data holds the FIFO
// head, and a word is consumed on a cycle where rd_en && out_valid.
module egress_port
    import pkt_pkg::*;
#(
    parameter int FIFO_DEPTH  = 512,
    parameter int BLOCK_WORDS = pkt_pkg::BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] packet_in,
    input  logic        packet_in_en,
    input  logic        rd_en,
    input  logic        stats_clr,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic [31:0] pkt_cnt,
    output logic [31:0] lat_last,
    output logic [31:0] lat_max,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    egress_state_e     state_q,     state_d;
    logic [WCNT_W-1:0] word_cnt_q,  word_cnt_d;
    logic [WCNT_W-1:0] len_words_q, len_words_d;
    logic [31:0]       ts_q,        ts_d;
    logic              done_q,      done_d;
    logic [31:0]       lat_new_q,   lat_new_d;
    logic [31:0]       curr_time_q;
    logic              err_now;

    logic [31:0] pkt_cnt_q,  pkt_cnt_d;
    logic [31:0] lat_last_q, lat_last_d;
    logic [31:0] lat_max_q,  lat_max_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] err_cnt_q,  err_cnt_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic        drop_now;
    logic [5:0]  len_field;

    assign len_field = packet_in[LEN_MSB:LEN_LSB];

    egress_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (packet_in_en),
        .pop_i   (rd_en),
        .wdata_i (packet_in),
        .rdata_o (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A full FIFO always has a valid head, so only a missing rd_en drops.
    assign drop_now = packet_in_en && fifo_full && !rd_en;

    // Free-running timebase shared (via reset) with the ingress side.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) curr_time_q <= '0;
        else       curr_time_q <= curr_time_q + 32'd1;
    end

    // Packet delimiting FSM: next state, word counting, timestamp capture.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        len_words_d = len_words_q;
        ts_d        = ts_q;
        done_d      = 1'b0;
        lat_new_d   = lat_new_q;
        err_now     = 1'b0;
        if (packet_in_en) begin
            case (state_q)
                E_IDLE: begin
                    err_now     = (len_field == 6'd0);
                    len_words_d = WCNT_W'(fix_len(len_field)) * WCNT_W'(BLOCK_WORDS);
                    word_cnt_d  = WCNT_W'(1);
                    state_d     = E_HDR;
                end
                E_HDR: begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == WCNT_W'(W_TS)) begin
                        ts_d    = packet_in;
                        state_d = E_BODY;
                    end
                end
                E_BODY: begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == len_words_q - 1'b1) begin
                        done_d    = 1'b1;
                        lat_new_d = curr_time_q - ts_q;
                        state_d   = E_IDLE;
                    end
                end
                default: state_d = E_IDLE;
            endcase
        end
    end

    // FSM and completion-pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= E_IDLE;
            word_cnt_q  <= '0;
            len_words_q <= '0;
            ts_q        <= '0;
            done_q      <= 1'b0;
            lat_new_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            len_words_q <= len_words_d;
            ts_q        <= ts_d;
            done_q      <= done_d;
            lat_new_q   <= lat_new_d;
        end
    end

    // Statistics update: a clear zeroes first, then this cycle's events land on top.
    always_comb begin
        pkt_cnt_d  = stats_clr ? 32'd0 : pkt_cnt_q;
        lat_last_d = stats_clr ? 32'd0 : lat_last_q;
        lat_max_d  = stats_clr ? 32'd0 : lat_max_q;
        drop_cnt_d = stats_clr ? 16'd0 : drop_cnt_q;
        err_cnt_d  = stats_clr ? 16'd0 : err_cnt_q;
        if (done_q) begin
            pkt_cnt_d  = pkt_cnt_d + 32'd1;
            lat_last_d = lat_new_q;
            if (lat_new_q > lat_max_d) lat_max_d = lat_new_q;
        end
        if (drop_now && drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
        if (err_now && err_cnt_d != 16'hFFFF)   err_cnt_d  = err_cnt_d + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            lat_last_q <= '0;
            lat_max_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            lat_last_q <= lat_last_d;
            lat_max_q  <= lat_max_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = !fifo_empty;
    assign pkt_cnt   = pkt_cnt_q;
    assign lat_last  = lat_last_q;
    assign lat_max   = lat_max_q;
    assign drop_cnt  = drop_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != E_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_egress_port.sv
// Directed bench for egress_port: one default-depth instance and one
// 16-deep instance share all inputs; the small one is used for overflow.
module tb_egress_port;

    logic        clk;
    logic        reset;
    logic [31:0] packet_in;
    logic        packet_in_en;
    logic        rd_en;
    logic        stats_clr;

    logic [31:0] out_data,  out_data16;
    logic        out_valid, out_valid16;
    logic [31:0] pkt_cnt,   pkt_cnt16;
    logic [31:0] lat_last,  lat_last16;
    logic [31:0] lat_max,   lat_max16;
    logic [15:0] drop_cnt,  drop_cnt16;
    logic [15:0] err_cnt,   err_cnt16;
    logic        busy,      busy16;
    logic [1:0]  state_dbg, state_dbg16;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tb_time;
    int          pkt_seq = 0;

    egress_port #(.FIFO_DEPTH(512)) dut (
        .clk(clk), .reset(reset), .packet_in(packet_in), .packet_in_en(packet_in_en),
        .rd_en(rd_en), .stats_clr(stats_clr), .out_data(out_data), .out_valid(out_valid),
        .pkt_cnt(pkt_cnt), .lat_last(lat_last), .lat_max(lat_max), .drop_cnt(drop_cnt),
        .err_cnt(err_cnt), .busy(busy), .state_dbg(state_dbg)
    );

    egress_port #(.FIFO_DEPTH(16)) dut16 (
        .clk(clk), .reset(reset), .packet_in(packet_in), .packet_in_en(packet_in_en),
        .rd_en(rd_en), .stats_clr(stats_clr), .out_data(out_data16), .out_valid(out_valid16),
        .pkt_cnt(pkt_cnt16), .lat_last(lat_last16), .lat_max(lat_max16), .drop_cnt(drop_cnt16),
        .err_cnt(err_cnt16), .busy(busy16), .state_dbg(state_dbg16)
    );

    // Clock and reference timebase (value the DUT samples at the next posedge).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) tb_time <= 32'd0;
        else       tb_time <= tb_time + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        packet_in_en = 1'b0;
        rd_en = 1'b0;
        stats_clr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Idle until the DUT will sample curr_time == t on the next posedge.
    task automatic wait_time(input logic [31:0] t);
        int guard;
        guard = 0;
        while (tb_time != t && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (tb_time != t) check("wait_time", tb_time, t);
    endtask

    // Drive nwords of a packet with length field l and timestamp ts,
    // idling gap cycles between words with junk on the data bus.
    task automatic send_pkt(input logic [5:0] l, input logic [31:0] ts,
                            input int gap, input int nwords);
        logic [31:0] w;
        pkt_seq++;
        for (int i = 0; i < nwords; i++) begin
            if (i == 0)      w = {5'd0, l, 5'd0, 16'hAB00 | 16'(pkt_seq)};
            else if (i == 1) w = 32'h1234_0000 | 32'(pkt_seq);
            else if (i == 2) w = ts;
            else             w = 32'hC000_0000 | (32'(pkt_seq) << 8) | 32'(i);
            packet_in    = w;
            packet_in_en = 1'b1;
            exp_q.push_back(w);
            @(negedge clk);
            packet_in_en = 1'b0;
            packet_in    = 32'hDEAD_BEEF;
            if (i < nwords - 1) repeat (gap) @(negedge clk);
        end
    endtask

    // Pop n words from the selected instance and compare against exp_q.
    task automatic drain(input int n, input bit sel16);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check("out_valid", sel16 ? 32'(out_valid16) : 32'(out_valid), 32'd1);
            check("out_data", sel16 ? out_data16 : out_data, e);
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        packet_in    = '0;
        packet_in_en = 1'b0;
        rd_en        = 1'b0;
        stats_clr    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_lat_max", lat_max, 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);

        // Single packet: ts=100, last word at 130 -> latency 30
        wait_time(123);
        send_pkt(6'd1, 32'd100, 0, 8);
        repeat (2) @(negedge clk);
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_lat_last", lat_last, 30);
        check("t1_lat_max", lat_max, 30);
        check("t1_err", 32'(err_cnt), 0);
        drain(8, 1'b0);
        check("t1_empty", 32'(out_valid), 0);

        // Back-to-back L=2 (last at 75, ts 25) then L=1 (last at 83, ts 63)
        do_reset();
        wait_time(60);
        send_pkt(6'd2, 32'd25, 0, 16);
        send_pkt(6'd1, 32'd63, 0, 8);
        repeat (2) @(negedge clk);
        check("t2_pkt_cnt", pkt_cnt, 2);
        check("t2_lat_last", lat_last, 20);
        check("t2_lat_max", lat_max, 50);
        drain(24, 1'b0);
        check("t2_empty", 32'(out_valid), 0);

        // Gaps of 5 idle cycles: word0 at 20, last at 62, ts 40 -> 22
        do_reset();
        wait_time(20);
        send_pkt(6'd1, 32'd40, 5, 8);
        repeat (2) @(negedge clk);
        check("t3_pkt_cnt", pkt_cnt, 1);
        check("t3_lat_last", lat_last, 22);
        drain(8, 1'b0);

        // Overflow on the 16-deep instance with no reads
        do_reset();
        wait_time(5);
        send_pkt(6'd3, 32'd5, 0, 24);
        repeat (2) @(negedge clk);
        check("t4_drop16", 32'(drop_cnt16), 8);
        check("t4_pkt16", pkt_cnt16, 1);
        check("t4_drop512", 32'(drop_cnt), 0);
        check("t4_lat16", lat_last16, 23);
        drain(16, 1'b1);
        check("t4_empty16", 32'(out_valid16), 0);
        exp_q.delete();
        send_pkt(6'd1, 32'd0, 0, 8);
        repeat (2) @(negedge clk);
        check("t4_drop16_hold", 32'(drop_cnt16), 8);
        check("t4_pkt16_2", pkt_cnt16, 2);
        drain(8, 1'b1);

        // Zero length with wrapping latency: ts FFFFFFF0, last at 0x10 -> 0x20
        do_reset();
        wait_time(9);
        send_pkt(6'd0, 32'hFFFF_FFF0, 0, 8);
        repeat (2) @(negedge clk);
        check("t5_err", 32'(err_cnt), 1);
        check("t5_pkt_cnt", pkt_cnt, 1);
        check("t5_lat_last", lat_last, 32'h20);
        check("t5_lat_max", lat_max, 32'h20);
        check("t5_busy", 32'(busy), 0);
        drain(8, 1'b0);
        check("t5_empty", 32'(out_valid), 0);

        // Async reset mid-packet, then a full packet
        do_reset();
        wait_time(5);
        send_pkt(6'd1, 32'd0, 0, 4);
        check("t6_busy_mid", 32'(busy), 1);
        check("t6_state_mid", 32'(state_dbg), 2);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_pkt", pkt_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        wait_time(5);
        send_pkt(6'd1, 32'd2, 0, 8);
        repeat (2) @(negedge clk);
        check("t6_pkt_cnt", pkt_cnt, 1);
        check("t6_lat_last", lat_last, 10);
        drain(8, 1'b0);
        check("t6_empty", 32'(out_valid), 0);

        // Clear racing a completion: prior L=0 packet (lat 50), then lat 20
        do_reset();
        wait_time(60);
        send_pkt(6'd0, 32'd17, 0, 8);
        repeat (2) @(negedge clk);
        check("t7_pre_pkt", pkt_cnt, 1);
        check("t7_pre_max", lat_max, 50);
        check("t7_pre_err", 32'(err_cnt), 1);
        wait_time(80);
        send_pkt(6'd1, 32'd67, 0, 8);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        check("t7_pkt_cnt", pkt_cnt, 1);
        check("t7_lat_last", lat_last, 20);
        check("t7_lat_max", lat_max, 20);
        check("t7_err", 32'(err_cnt), 0);
        drain(16, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
